fpu_inflight_tracker: RTL and testbench

Tracks every FPU operation in flight through the 5-stage FPU pipeline. It produces the per-stage descriptors that the FPU hazard detector consumes: `is_regwrite_k`, `is_legal_k`, `is_hazard_k` and `rdi_k`. It also signals the writeback of the oldest op. The block sits between FPU issue and the hazard detector: issue pushes a descriptor in, and the descriptor shifts one stage per unstalled cycle. A per-entry countdown models result latency, so `is_hazard_k` drops as soon as the result can be forwarded.

---
 rtl/fpu_inflight_tracker.sv | 134 +++++++++++++
 tb/tb_fpu_inflight_tracker.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_inflight_tracker.sv
// Per-stage descriptor tracker for the 5-stage FPU pipeline. It feeds the hazard detector
// with legal/regwrite/hazard/rd per stage and flags writeback of the oldest op.
module fpu_inflight_tracker #(
  parameter int DEPTH = 5,
  parameter int RW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid,
  input  logic          issue_regwrite,
  input  logic [RW-1:0] issue_rd,
  input  logic [2:0]    issue_lat,
  input  logic          stall,
  input  logic          flush,
  output logic          is_legal_0,
  output logic          is_legal_1,
  output logic          is_legal_2,
  output logic          is_legal_3,
  output logic          is_legal_4,
  output logic          is_regwrite_0,
  output logic          is_regwrite_1,
  output logic          is_regwrite_2,
  output logic          is_regwrite_3,
  output logic          is_regwrite_4,
  output logic          is_hazard_0,
  output logic          is_hazard_1,
  output logic          is_hazard_2,
  output logic          is_hazard_3,
  output logic          is_hazard_4,
  output logic [RW-1:0] rdi_0,
  output logic [RW-1:0] rdi_1,
  output logic [RW-1:0] rdi_2,
  output logic [RW-1:0] rdi_3,
  output logic [RW-1:0] rdi_4,
  output logic          wb_valid,
  output logic [RW-1:0] wb_rd,
  output logic          busy
);

  localparam logic [2:0] MAX_LAT = 3'(DEPTH);

  logic          legal    [DEPTH];
  logic          regwrite [DEPTH];
  logic [RW-1:0] rd       [DEPTH];
  logic [2:0]    cnt      [DEPTH];
  logic [2:0]    entry_cnt;

  function automatic logic [2:0] dec_sat(input logic [2:0] c);
    return (c == 3'd0) ? 3'd0 : c - 3'd1;
  endfunction

  // Clamp the requested latency into 1..DEPTH before turning it into a countdown.
  always_comb begin
    entry_cnt = 3'd0;
    if (issue_lat == 3'd0)
      entry_cnt = 3'd0;
    else if (issue_lat > MAX_LAT)
      entry_cnt = MAX_LAT - 3'd1;
    else
      entry_cnt = issue_lat - 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        legal[k]    <= 1'b0;
        regwrite[k] <= 1'b0;
        rd[k]       <= '0;
        cnt[k]      <= 3'd0;
      end
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        legal[k]    <= 1'b0;
        regwrite[k] <= 1'b0;
        rd[k]       <= '0;
        cnt[k]      <= 3'd0;
      end
    end else if (stall) begin
      // Positions freeze but the functional unit keeps computing.
      for (int k = 0; k < DEPTH; k++)
        cnt[k] <= dec_sat(cnt[k]);
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        legal[k]    <= legal[k-1];
        regwrite[k] <= regwrite[k-1];
        rd[k]       <= rd[k-1];
        cnt[k]      <= dec_sat(cnt[k-1]);
      end
      if (issue_valid) begin
        legal[0]    <= 1'b1;
        regwrite[0] <= issue_regwrite;
        rd[0]       <= issue_rd;
        cnt[0]      <= entry_cnt;
      end else begin
        legal[0]    <= 1'b0;
        regwrite[0] <= 1'b0;
        rd[0]       <= '0;
        cnt[0]      <= 3'd0;
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < DEPTH; k++)
      busy = busy | legal[k];
  end

  assign is_legal_0    = legal[0];
  assign is_legal_1    = legal[1];
  assign is_legal_2    = legal[2];
  assign is_legal_3    = legal[3];
  assign is_legal_4    = legal[4];
  assign is_regwrite_0 = regwrite[0];
  assign is_regwrite_1 = regwrite[1];
  assign is_regwrite_2 = regwrite[2];
  assign is_regwrite_3 = regwrite[3];
  assign is_regwrite_4 = regwrite[4];
  assign is_hazard_0   = legal[0] & (cnt[0] != 3'd0);
  assign is_hazard_1   = legal[1] & (cnt[1] != 3'd0);
  assign is_hazard_2   = legal[2] & (cnt[2] != 3'd0);
  assign is_hazard_3   = legal[3] & (cnt[3] != 3'd0);
  assign is_hazard_4   = legal[4] & (cnt[4] != 3'd0);
  assign rdi_0         = rd[0];
  assign rdi_1         = rd[1];
  assign rdi_2         = rd[2];
  assign rdi_3         = rd[3];
  assign rdi_4         = rd[4];

  // A stalled or flushed oldest op must not be reported as retiring.
  assign wb_valid = legal[4] & regwrite[4] & ~stall & ~flush;
  assign wb_rd    = rd[4];

endmodule

// File: tb/tb_fpu_inflight_tracker.sv
// Randomized plus directed bench for fpu_inflight_tracker, checked every cycle against
// an op-list model that tracks each op's position and elapsed cycles.
module tb_fpu_inflight_tracker;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          issue_valid = 1'b0;
  logic          issue_regwrite = 1'b0;
  logic [RW-1:0] issue_rd = '0;
  logic [2:0]    issue_lat = 3'd0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          is_legal_0, is_legal_1, is_legal_2, is_legal_3, is_legal_4;
  logic          is_regwrite_0, is_regwrite_1, is_regwrite_2, is_regwrite_3, is_regwrite_4;
  logic          is_hazard_0, is_hazard_1, is_hazard_2, is_hazard_3, is_hazard_4;
  logic [RW-1:0] rdi_0, rdi_1, rdi_2, rdi_3, rdi_4;
  logic          wb_valid;
  logic [RW-1:0] wb_rd;
  logic          busy;

  fpu_inflight_tracker #(.DEPTH(5), .RW(RW)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_regwrite(issue_regwrite),
    .issue_rd(issue_rd), .issue_lat(issue_lat),
    .stall(stall), .flush(flush),
    .is_legal_0(is_legal_0), .is_legal_1(is_legal_1), .is_legal_2(is_legal_2),
    .is_legal_3(is_legal_3), .is_legal_4(is_legal_4),
    .is_regwrite_0(is_regwrite_0), .is_regwrite_1(is_regwrite_1), .is_regwrite_2(is_regwrite_2),
    .is_regwrite_3(is_regwrite_3), .is_regwrite_4(is_regwrite_4),
    .is_hazard_0(is_hazard_0), .is_hazard_1(is_hazard_1), .is_hazard_2(is_hazard_2),
    .is_hazard_3(is_hazard_3), .is_hazard_4(is_hazard_4),
    .rdi_0(rdi_0), .rdi_1(rdi_1), .rdi_2(rdi_2), .rdi_3(rdi_3), .rdi_4(rdi_4),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [4:0]    legal_v, regw_v, haz_v;
  logic [RW-1:0] rd_v [5];
  assign legal_v = {is_legal_4, is_legal_3, is_legal_2, is_legal_1, is_legal_0};
  assign regw_v  = {is_regwrite_4, is_regwrite_3, is_regwrite_2, is_regwrite_1, is_regwrite_0};
  assign haz_v   = {is_hazard_4, is_hazard_3, is_hazard_2, is_hazard_1, is_hazard_0};
  assign rd_v[0] = rdi_0;
  assign rd_v[1] = rdi_1;
  assign rd_v[2] = rdi_2;
  assign rd_v[3] = rdi_3;
  assign rd_v[4] = rdi_4;

  // Each in-flight op: its stage position and how many edges it has lived through.
  typedef struct {
    bit rw;
    int rd;
    int lat;
    int elapsed;
    int pos;
  } op_t;
  op_t q[$];

  int passed = 0;
  int total  = 0;

  function automatic int eff_lat(input int lat);
    if (lat == 0) return 1;
    if (lat > 5) return 5;
    return lat;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  task automatic checkOutput();
    bit el, er, eh;
    int erd;
    bit ewv;
    int ewr;
    ewv = 0;
    ewr = 0;
    for (int k = 0; k < 5; k++) begin
      el = 0; er = 0; eh = 0; erd = 0;
      foreach (q[i]) begin
        if (q[i].pos == k) begin
          el  = 1;
          er  = q[i].rw;
          erd = q[i].rd;
          eh  = (q[i].lat - 1 - q[i].elapsed) > 0;
        end
      end
      chk($sformatf("is_legal_%0d", k), 32'(legal_v[k]), 32'(el));
      chk($sformatf("is_regwrite_%0d", k), 32'(regw_v[k]), 32'(er));
      chk($sformatf("is_hazard_%0d", k), 32'(haz_v[k]), 32'(eh));
      chk($sformatf("rdi_%0d", k), 32'(rd_v[k]), 32'(erd));
      if (k == 4) begin
        ewv = el && er && !stall && !flush;
        ewr = erd;
      end
    end
    chk("wb_valid", 32'(wb_valid), 32'(ewv));
    chk("wb_rd", 32'(wb_rd), 32'(ewr));
    chk("busy", 32'(busy), 32'(q.size() != 0));
  endtask

  // Drive one cycle's inputs (called right after a falling edge) and check the outputs.
  task automatic applyStimulus(input bit v, input bit rw, input int rd, input int lat,
                               input bit st, input bit fl);
    issue_valid    = v;
    issue_regwrite = rw;
    issue_rd       = RW'(rd);
    issue_lat      = 3'(lat);
    stall          = st;
    flush          = fl;
    #1 checkOutput();
  endtask

  task automatic clockEdge();
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else if (stall) begin
      foreach (q[i]) q[i].elapsed++;
    end else begin
      foreach (q[i]) begin
        q[i].elapsed++;
        q[i].pos++;
      end
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].pos > 4) q.delete(i);
      if (issue_valid)
        q.push_back('{issue_regwrite, int'(issue_rd), eff_lat(int'(issue_lat)), 0, 0});
    end
    #1;
  endtask

  task automatic cycle(input bit v, input bit rw, input int rd, input int lat,
                       input bit st, input bit fl);
    @(negedge clk);
    applyStimulus(v, rw, rd, lat, st, fl);
    clockEdge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 1, 0, 0);
  endtask

  // Raise reset part-way through the high phase, then release at the falling edge.
  task automatic asyncReset();
    #2 rst = 1'b1;
    #1 q.delete();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_legal", 32'(legal_v), 32'd0);
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 1, 0, 0);
    clockEdge();
    chk("rst_busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #1 checkOutput();
    chk("init_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 1, 0, 0);
    clockEdge();

    $display("[TB] reset with ops in flight");
    cycle(1, 1, 3, 5, 0, 0);
    cycle(1, 1, 4, 5, 0, 0);
    cycle(1, 1, 5, 5, 0, 0);
    asyncReset();

    $display("[TB] single op");
    cycle(1, 1, 7, 3, 0, 0);
    chk("single_legal0", 32'(is_legal_0), 32'd1);
    chk("single_haz0", 32'(is_hazard_0), 32'd1);
    idle(1);
    chk("single_haz1", 32'(is_hazard_1), 32'd1);
    idle(1);
    chk("single_legal2", 32'(is_legal_2), 32'd1);
    chk("single_haz2", 32'(is_hazard_2), 32'd0);
    idle(2);
    chk("single_wb_valid", 32'(wb_valid), 32'd1);
    chk("single_wb_rd", 32'(wb_rd), 32'd7);
    idle(1);
    chk("single_busy_after", 32'(busy), 32'd0);

    $display("[TB] stall with countdown");
    cycle(1, 1, 3, 4, 0, 0);
    chk("stall_haz0_entry", 32'(is_hazard_0), 32'd1);
    cycle(0, 0, 0, 1, 1, 0);
    chk("stall_legal0_a", 32'(is_legal_0), 32'd1);
    chk("stall_haz0_a", 32'(is_hazard_0), 32'd1);
    cycle(0, 0, 0, 1, 1, 0);
    chk("stall_legal0_b", 32'(is_legal_0), 32'd1);
    chk("stall_haz0_b", 32'(is_hazard_0), 32'd1);
    idle(1);
    chk("stall_legal1", 32'(is_legal_1), 32'd1);
    chk("stall_haz1", 32'(is_hazard_1), 32'd0);
    idle(2);
    chk("stall_no_wb_early", 32'(wb_valid), 32'd0);
    idle(1);
    chk("stall_wb_valid", 32'(wb_valid), 32'd1);
    chk("stall_wb_rd", 32'(wb_rd), 32'd3);
    idle(1);

    $display("[TB] flush");
    cycle(1, 1, 11, 2, 0, 0);
    idle(1);
    cycle(1, 1, 12, 2, 0, 0);
    idle(1);
    cycle(1, 1, 13, 2, 0, 0);
    chk("flush_pre_legal", 32'(legal_v), 32'h15);
    @(negedge clk);
    applyStimulus(1, 1, 9, 3, 1, 1);
    chk("flush_wb_valid", 32'(wb_valid), 32'd0);
    clockEdge();
    chk("flush_legal", 32'(legal_v), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);

    $display("[TB] latency clamp");
    cycle(1, 1, 1, 0, 0, 0);
    chk("clamp0_legal0", 32'(is_legal_0), 32'd1);
    chk("clamp0_haz0", 32'(is_hazard_0), 32'd0);
    cycle(1, 1, 2, 7, 0, 0);
    chk("clamp7_haz0", 32'(is_hazard_0), 32'd1);
    chk("clamp0_haz1", 32'(is_hazard_1), 32'd0);
    idle(1);
    chk("clamp7_haz1", 32'(is_hazard_1), 32'd1);
    idle(1);
    chk("clamp7_haz2", 32'(is_hazard_2), 32'd1);
    idle(1);
    chk("clamp7_haz3", 32'(is_hazard_3), 32'd1);
    idle(1);
    chk("clamp7_legal4", 32'(is_legal_4), 32'd1);
    chk("clamp7_haz4", 32'(is_hazard_4), 32'd0);
    cycle(1, 1, 3, 5, 0, 0);
    idle(5);

    $display("[TB] non-writing ops");
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, i + 1, 2, 0, 0);
      chk("nowr_wb_fill", 32'(wb_valid), 32'd0);
    end
    chk("nowr_legal", 32'(legal_v), 32'h1f);
    chk("nowr_busy", 32'(busy), 32'd1);
    chk("nowr_regwrite", 32'(regw_v), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      applyStimulus(0, 0, 0, 1, 0, 0);
      chk("nowr_wb_drain", 32'(wb_valid), 32'd0);
      clockEdge();
    end

    $display("[TB] randomized traffic");
    for (int n = 0; n < 1500; n++) begin
      cycle($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
            $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 4);
      if ($urandom_range(0, 299) == 0) asyncReset();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
